// File: rtl/uart_pkg.sv
// Items shared by the UART transmitter and receiver: FSM state encoding and
// default link timing parameters.
package uart_pkg;

  // Frame phases; the receiver walks the same four phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Default clk cycles per serial bit.
  localparam int UART_CLKS_PER_BIT_DEF = 16;

  // Default data bits per frame (8N1).
  localparam int UART_DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and pulses bit_done_o on the
// terminal count, then wraps to 0. While clr_i is high the counter is held at
// zero, so the first period after clr_i drops is a full CLKS_PER_BIT cycles.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic srst_i,
  input  logic clr_i,
  output logic bit_done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done_o = !clr_i && (cnt_q == CNT_LAST);

  // Next count: hold at zero when cleared, wrap at terminal count, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || bit_done_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style serial transmitter. A word is taken over a valid/ready handshake
// and shifted out LSB first between a low start bit and a high stop bit.
// The line output is registered so the start bit begins on the accept edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = UART_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_done;
  logic                 accept;
  logic                 baud_clr;

  // Ready depends only on state and reset so a producer can never create a
  // combinational loop through tx_valid.
  assign tx_ready = (state_q == ST_IDLE) && !reset;
  assign accept   = tx_valid && tx_ready;
  // The bit timer is parked at zero while idle so the start bit gets a full period.
  assign baud_clr = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .srst_i    (reset),
    .clr_i     (baud_clr),
    .bit_done_o(bit_done)
  );

  // Next-state logic: frame sequencing, shift register, bit index and line value.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d = ST_START;
          shreg_d = tx_data;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            // shreg_q[0] is on the line now; bit 1 becomes the new LSB.
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed table, back-to-back, reset abort,
// a narrow 2-clk/5-bit instance, and randomized frames against a line model.
module tb_uart_tx;

  localparam int N     = 4;
  localparam int FRAME = 10 * N;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  logic [4:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       tx2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  logic last_wave [0:FRAME-1];
  logic wave4 [0:89];

  uart_tx #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data2),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
    .tx      (tx2),
    .busy    (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         chg;
    logic [7:0] chg_data;
    logic [9:0] exp_frame;  // bit k = k-th bit on the line (start, d0..d7, stop)
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line value c cycles after the accept edge, from the frame definition.
  function automatic logic model_line(input logic [7:0] d, input int c);
    int b;
    b = c / N;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return d[b-1];
  endfunction

  // Called just after a negedge with the line idle. Sends one word and checks
  // every cycle of the frame plus the following idle cycle.
  task automatic run_frame(input logic [7:0] d, input bit chg, input logic [7:0] chg_d,
                           input bit junk);
    int mism;
    mism = 0;
    check("ready_before_send", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      last_wave[c] = tx;
      if (tx !== model_line(d, c) || busy !== 1'b1 || tx_ready !== 1'b0) mism++;
      if (c == 0) begin
        tx_valid = 1'b0;
        if (chg) tx_data = chg_d;
      end
      if (junk) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end
      if (c == FRAME - 1) tx_valid = 1'b0;
    end
    check("frame_model", mism, 0);
    @(negedge clk);
    check("idle_after_frame", {tx, busy, tx_ready}, 3'b101);
    $display("frame data=0x%02h sent, cycle mismatches=%0d", d, mism);
  endtask

  // Compare the last captured frame against a hand-written bit pattern,
  // requiring each bit to occupy exactly N cycles.
  task automatic check_bits(input logic [9:0] exp_frame, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < N; j++)
        if (last_wave[k*N + j] !== exp_frame[k]) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    int a2;
    int bad;
    int gap;
    logic [6:0] f2;
    logic exp_l;

    vecs[0] = '{data: 8'h55, chg: 1'b0, chg_data: 8'h00, exp_frame: 10'h2AA};
    vecs[1] = '{data: 8'hA3, chg: 1'b1, chg_data: 8'hFF, exp_frame: 10'h346};
    vecs[2] = '{data: 8'h00, chg: 1'b0, chg_data: 8'h00, exp_frame: 10'h200};
    vecs[3] = '{data: 8'hFF, chg: 1'b0, chg_data: 8'h00, exp_frame: 10'h3FE};

    // Reset held 3 cycles with tx_valid high: nothing may be accepted.
    reset     = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 8'h3C;
    tx_valid2 = 1'b0;
    tx_data2  = 5'h00;
    repeat (3) begin
      @(negedge clk);
      check("reset_state", {tx, busy, tx_ready}, 3'b100);
    end
    check("reset_state_n2d5", {tx2, busy2, tx_ready2}, 3'b100);
    reset    = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {tx, busy, tx_ready}, 3'b101);
    $display("reset sequence done");

    // Table-driven single frames.
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].data, vecs[i].chg, vecs[i].chg_data, 1'b0);
      check_bits(vecs[i].exp_frame, "table_bits");
    end

    // Back-to-back: tx_valid held, second word queued right after the first accept.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    a2 = -1;
    for (int n = 1; n <= 82; n++) begin
      @(negedge clk);
      wave4[n-1] = tx;
      if (n == 1) tx_data = 8'hFF;
      if (a2 < 0 && tx_valid && tx_ready === 1'b1) a2 = n;
      else if (a2 >= 0) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    check("b2b_accept_spacing", a2, 41);
    bad = 0;
    for (int c = 0; c < 82; c++) begin
      if (c < FRAME) exp_l = model_line(8'h00, c);
      else if (c == FRAME) exp_l = 1'b1;
      else if (c < 2*FRAME + 1) exp_l = model_line(8'hFF, c - FRAME - 1);
      else exp_l = 1'b1;
      if (wave4[c] !== exp_l) bad++;
    end
    check("b2b_wave", bad, 0);
    @(negedge clk);
    check("b2b_idle_end", {tx, busy, tx_ready}, 3'b101);
    $display("back-to-back 0x00,0xFF sent, second accept at +%0d", a2);

    // Reset during data bit 3 of 0x0F, then a clean 0x81 frame.
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (tx !== model_line(8'h0F, c)) bad++;
      if (c == 0) tx_valid = 1'b0;
    end
    check("abort_prefix", bad, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", {tx, busy, tx_ready}, 3'b100);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_abort", tx_ready, 1);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no_residual_bits", bad, 0);
    $display("frame data=0x0F aborted by reset");
    run_frame(8'h81, 1'b0, 8'h00, 1'b0);
    check_bits(10'h302, "post_abort_bits");

    // Narrow instance: 2 clks/bit, 5 data bits, word 5'h15.
    f2 = 7'h6A;
    check("n2d5_ready", tx_ready2, 1);
    tx_data2  = 5'h15;
    tx_valid2 = 1'b1;
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (tx2 !== f2[c/2] || busy2 !== 1'b1 || tx_ready2 !== 1'b0) bad++;
      if (c == 0) tx_valid2 = 1'b0;
    end
    check("n2d5_frame", bad, 0);
    @(negedge clk);
    check("n2d5_idle", {tx2, busy2, tx_ready2}, 3'b101);
    $display("frame data=0x15 sent on 2-clk/5-bit instance, mismatches=%0d", bad);

    // Random words with random gaps and junk handshake activity mid-frame.
    for (int i = 0; i < 12; i++) begin
      run_frame(8'($urandom), 1'b0, 8'h00, 1'b1);
      gap = $urandom_range(0, 4);
      bad = 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if ({tx, busy, tx_ready} !== 3'b101) bad++;
      end
      check("random_gap_idle", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
